bell_buzzer_drv_57: RTL and testbench

Pattern generator at the far end of the bell interface. It consumes the `sound_e_57` / `sound_model_57` pair from the alarm/hourly-chime comparator. It turns each new request into a timed beep sequence: a tone square wave on the buzzer pin plus a mirrored LED. It returns a one-cycle done pulse when the sequence ends or the user silences it.

---
 rtl/bell_buzzer_drv_57_if.sv | 31 +++
 rtl/bell_buzzer_drv_57.sv | 175 +++++++++++++++++
 tb/tb_bell_buzzer_drv_57.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bell_buzzer_drv_57_if.sv
// Request/response bundle between the chime comparator and the bell pattern generator.
// The requester drives the sound request and silence key; the driver returns the pin and status levels.
interface bell_buzzer_drv_57_if;
    logic sound_e_57;
    logic sound_model_57;
    logic stop_57;
    logic buzzer_57;
    logic led_57;
    logic busy_57;
    logic done_57;

    modport master (
        output sound_e_57,
        output sound_model_57,
        output stop_57,
        input  buzzer_57,
        input  led_57,
        input  busy_57,
        input  done_57
    );

    modport slave (
        input  sound_e_57,
        input  sound_model_57,
        input  stop_57,
        output buzzer_57,
        output led_57,
        output busy_57,
        output done_57
    );
endinterface

// File: rtl/bell_buzzer_drv_57.sv
// Bell pattern generator: turns each rising request edge into a timed series of tone beeps
// (alarm or hourly chime), mirrors ON phases on an LED and pulses done at the end or on silence.
module bell_buzzer_drv_57 #(
    parameter int MS_DIV       = 50000,
    parameter int ALARM_HALF   = 12500,
    parameter int CHIME_HALF   = 25000,
    parameter int ALARM_ON_MS  = 500,
    parameter int ALARM_OFF_MS = 500,
    parameter int ALARM_BEEPS  = 60,
    parameter int CHIME_ON_MS  = 200,
    parameter int CHIME_OFF_MS = 200,
    parameter int CHIME_BEEPS  = 3
) (
    input  logic                    clk_50m_57,
    input  logic                    rst_n_57,
    bell_buzzer_drv_57_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [15:0] PRESC_M1 = 16'(MS_DIV - 1);

    // Per-mode timing tables, index 0 = alarm, 1 = chime; stored as terminal (N-1) values.
    logic [15:0] half_m1_tab [2];
    logic [9:0]  on_m1_tab   [2];
    logic [9:0]  off_m1_tab  [2];
    logic [6:0]  beeps_tab   [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mode
            localparam int HALF  = (gi == 0) ? ALARM_HALF   : CHIME_HALF;
            localparam int ON_T  = (gi == 0) ? ALARM_ON_MS  : CHIME_ON_MS;
            localparam int OFF_T = (gi == 0) ? ALARM_OFF_MS : CHIME_OFF_MS;
            localparam int BEEPS = (gi == 0) ? ALARM_BEEPS  : CHIME_BEEPS;
            assign half_m1_tab[gi] = 16'(HALF - 1);
            assign on_m1_tab[gi]   = 10'(ON_T - 1);
            assign off_m1_tab[gi]  = 10'(OFF_T - 1);
            assign beeps_tab[gi]   = 7'(BEEPS);
        end
    endgenerate

    state_t      state_reg;
    state_t      state_next;
    logic        e_d_reg;
    logic        mode_reg;
    logic [6:0]  beep_cnt_reg;
    logic [15:0] presc_reg;
    logic [9:0]  phase_reg;
    logic [15:0] tone_reg;
    logic        buzzer_reg;
    logic        stop_done_reg;

    logic        start;
    logic        preempt;
    logic        tick;
    logic        on_end;
    logic        off_end;
    logic        end_now;
    logic        load_seq;
    logic        stop_done_next;

    assign start   = bus.sound_e_57 & ~e_d_reg;
    // Only an alarm request may cut short a running chime.
    assign preempt = start & ~bus.sound_model_57 & mode_reg;
    assign tick    = (presc_reg == PRESC_M1);
    assign on_end  = tick && (phase_reg == on_m1_tab[mode_reg]);
    assign off_end = tick && (phase_reg == off_m1_tab[mode_reg]);
    assign end_now = (state_reg == ST_OFF) && off_end && (beep_cnt_reg == 7'd0);

    always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
        if (!rst_n_57) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_seq       = 1'b0;
        stop_done_next = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load_seq   = 1'b1;
                    state_next = ST_ON;
                end
            end
            ST_ON: begin
                if (bus.stop_57) begin
                    state_next     = ST_IDLE;
                    stop_done_next = 1'b1;
                end else if (preempt) begin
                    load_seq   = 1'b1;
                    state_next = ST_ON;
                end else if (on_end) begin
                    state_next = ST_OFF;
                end
            end
            ST_OFF: begin
                if (bus.stop_57) begin
                    state_next     = ST_IDLE;
                    // A natural end already pulses done this cycle; avoid a second pulse.
                    stop_done_next = ~end_now;
                end else if (preempt) begin
                    load_seq   = 1'b1;
                    state_next = ST_ON;
                end else if (off_end) begin
                    state_next = (beep_cnt_reg == 7'd0) ? ST_IDLE : ST_ON;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
        if (!rst_n_57) begin
            e_d_reg       <= 1'b0;
            mode_reg      <= 1'b0;
            beep_cnt_reg  <= 7'd0;
            presc_reg     <= 16'd0;
            phase_reg     <= 10'd0;
            tone_reg      <= 16'd0;
            buzzer_reg    <= 1'b0;
            stop_done_reg <= 1'b0;
        end else begin
            e_d_reg       <= bus.sound_e_57;
            stop_done_reg <= stop_done_next;
            if (load_seq) begin
                mode_reg     <= bus.sound_model_57;
                beep_cnt_reg <= beeps_tab[bus.sound_model_57];
                presc_reg    <= 16'd0;
                phase_reg    <= 10'd0;
                tone_reg     <= 16'd0;
                buzzer_reg   <= 1'b1;
            end else if (state_next != state_reg) begin
                presc_reg  <= 16'd0;
                phase_reg  <= 10'd0;
                tone_reg   <= 16'd0;
                buzzer_reg <= (state_next == ST_ON);
                if (state_next == ST_OFF) begin
                    beep_cnt_reg <= beep_cnt_reg - 7'd1;
                end
            end else if (state_reg != ST_IDLE) begin
                if (tick) begin
                    presc_reg <= 16'd0;
                    phase_reg <= phase_reg + 10'd1;
                end else begin
                    presc_reg <= presc_reg + 16'd1;
                end
                if (state_reg == ST_ON) begin
                    if (tone_reg == half_m1_tab[mode_reg]) begin
                        tone_reg   <= 16'd0;
                        buzzer_reg <= ~buzzer_reg;
                    end else begin
                        tone_reg <= tone_reg + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.buzzer_57 = buzzer_reg & (state_reg == ST_ON);
    assign bus.led_57    = (state_reg == ST_ON);
    assign bus.busy_57   = (state_reg != ST_IDLE);
    assign bus.done_57   = end_now | stop_done_reg;

endmodule

// File: tb/tb_bell_buzzer_drv_57.sv
// Directed bench for bell_buzzer_drv_57 with small timing parameters; sequences are logged per
// cycle and checked against hand-computed beep counts, phase lengths and tone periods.
module tb_bell_buzzer_drv_57;

    localparam int MS_DIV       = 4;
    localparam int ALARM_HALF   = 2;
    localparam int CHIME_HALF   = 3;
    localparam int ALARM_ON_MS  = 3;
    localparam int ALARM_OFF_MS = 2;
    localparam int ALARM_BEEPS  = 4;
    localparam int CHIME_ON_MS  = 2;
    localparam int CHIME_OFF_MS = 2;
    localparam int CHIME_BEEPS  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bell_buzzer_drv_57_if bus();

    bell_buzzer_drv_57 #(
        .MS_DIV       (MS_DIV),
        .ALARM_HALF   (ALARM_HALF),
        .CHIME_HALF   (CHIME_HALF),
        .ALARM_ON_MS  (ALARM_ON_MS),
        .ALARM_OFF_MS (ALARM_OFF_MS),
        .ALARM_BEEPS  (ALARM_BEEPS),
        .CHIME_ON_MS  (CHIME_ON_MS),
        .CHIME_OFF_MS (CHIME_OFF_MS),
        .CHIME_BEEPS  (CHIME_BEEPS)
    ) u_dut (
        .clk_50m_57 (clk),
        .rst_n_57   (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit mode;
        bit hold;
        int exp_busy;
        int on_len;
        int off_len;
        int beeps;
        int half;
    } vec_t;

    vec_t vecs [3];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   s        = 0;
    logic bz_log   [0:255];
    logic led_log  [0:255];
    logic busy_log [0:255];
    logic done_log [0:255];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic clear_log();
        s = 0;
        for (int i = 0; i < 256; i++) begin
            bz_log[i]   = 1'b0;
            led_log[i]  = 1'b0;
            busy_log[i] = 1'b0;
            done_log[i] = 1'b0;
        end
    endtask

    // One clock; sample index s counts cycles after the edge that first sees the new inputs.
    task automatic step();
        @(posedge clk);
        #1;
        if (s < 255) s++;
        bz_log[s]   = bus.buzzer_57;
        led_log[s]  = bus.led_57;
        busy_log[s] = bus.busy_57;
        done_log[s] = bus.done_57;
    endtask

    function automatic int count_busy(input int first, input int last);
        int n = 0;
        for (int i = first; i <= last; i++) n += int'(busy_log[i]);
        return n;
    endfunction

    function automatic int count_done(input int first, input int last);
        int n = 0;
        for (int i = first; i <= last; i++) n += int'(done_log[i]);
        return n;
    endfunction

    task automatic analyze(input string tag, input int first, input int last, input int half,
                           input int on_len, input int off_len, input int beeps, input int exp_busy);
        int busy_cnt  = 0;
        int done_cnt  = 0;
        int done_idx  = -1;
        int pulses    = 0;
        int bad_pulse = 0;
        int bad_gap   = 0;
        int bad_tone  = 0;
        int gap       = 0;
        int j         = 0;
        for (int i = first; i <= last; i++) begin
            busy_cnt += int'(busy_log[i]);
            if (done_log[i]) begin
                done_cnt++;
                done_idx = i;
            end
            if (led_log[i]) begin
                if (i == first || !led_log[i-1]) begin
                    pulses++;
                    j = 0;
                    if (gap != 0 && gap != off_len) bad_gap++;
                    gap = 0;
                end
                if (bz_log[i] != (((j / half) % 2) == 0)) bad_tone++;
                j++;
            end else begin
                if (i > first && led_log[i-1] && j != on_len) bad_pulse++;
                if (bz_log[i]) bad_tone++;
                if (busy_log[i]) begin
                    gap++;
                end else if (gap != 0) begin
                    if (gap != off_len) bad_gap++;
                    gap = 0;
                end
            end
        end
        chk({tag, " busy_len"},     busy_cnt, exp_busy);
        chk({tag, " first_busy"},   int'(busy_log[first]), 1);
        chk({tag, " done_count"},   done_cnt, 1);
        chk({tag, " done_cycle"},   done_idx - first + 1, exp_busy);
        chk({tag, " beeps"},        pulses, beeps);
        chk({tag, " on_len_errs"},  bad_pulse, 0);
        chk({tag, " off_len_errs"}, bad_gap, 0);
        chk({tag, " tone_errs"},    bad_tone, 0);
        chk({tag, " idle_after"},   int'(busy_log[first + exp_busy]), 0);
    endtask

    initial begin
        // mode, hold, busy cycles, ON len, OFF len, beeps, tone half-period
        vecs[0] = '{mode: 1'b1, hold: 1'b1, exp_busy: 48, on_len: 8,  off_len: 8, beeps: 3, half: 3};
        vecs[1] = '{mode: 1'b0, hold: 1'b1, exp_busy: 80, on_len: 12, off_len: 8, beeps: 4, half: 2};
        vecs[2] = '{mode: 1'b1, hold: 1'b0, exp_busy: 48, on_len: 8,  off_len: 8, beeps: 3, half: 3};

        bus.sound_e_57     = 1'b0;
        bus.sound_model_57 = 1'b0;
        bus.stop_57        = 1'b0;
        rst_n              = 1'b0;
        clear_log();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({bus.buzzer_57, bus.led_57, bus.busy_57, bus.done_57}), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("idle_after_reset", count_busy(1, 10) + count_done(1, 10), 0);

        for (int v = 0; v < 3; v++) begin
            clear_log();
            bus.sound_model_57 = vecs[v].mode;
            bus.sound_e_57     = 1'b1;
            for (int i = 0; i < 100; i++) begin
                step();
                if (!vecs[v].hold && s == 10) bus.sound_e_57 = 1'b0;
            end
            bus.sound_e_57 = 1'b0;
            analyze($sformatf("vec%0d", v), 1, 100, vecs[v].half, vecs[v].on_len,
                    vecs[v].off_len, vecs[v].beeps, vecs[v].exp_busy);
            step();
            step();
        end

        // Stop in the 2nd alarm ON phase (samples 21..32), then a stray stop while idle.
        clear_log();
        bus.sound_model_57 = 1'b0;
        bus.sound_e_57     = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s == 5)  bus.sound_e_57 = 1'b0;
            if (s == 24) bus.stop_57 = 1'b1;
            if (s == 25) bus.stop_57 = 1'b0;
            if (s == 30) bus.stop_57 = 1'b1;
            if (s == 31) bus.stop_57 = 1'b0;
        end
        chk("stop pre_led",   int'(led_log[24]), 1);
        chk("stop busy",      int'(busy_log[25]), 0);
        chk("stop led_bz",    int'({led_log[25], bz_log[25]}), 0);
        chk("stop done",      int'(done_log[25]), 1);
        chk("stop done_next", int'(done_log[26]), 0);
        chk("stop done_total", count_done(1, 40), 1);
        chk("stop idle_busy", count_busy(26, 40), 0);

        // Alarm edge during the 2nd chime beep (samples 17..24) restarts as a full alarm at sample 19.
        clear_log();
        bus.sound_model_57 = 1'b1;
        bus.sound_e_57     = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step();
            if (s == 5) bus.sound_e_57 = 1'b0;
            if (s == 18) begin
                bus.sound_e_57     = 1'b1;
                bus.sound_model_57 = 1'b0;
            end
            if (s == 30) bus.sound_e_57 = 1'b0;
        end
        chk("preempt in_2nd_beep", int'(led_log[18]), 1);
        chk("preempt prefix_busy", count_busy(1, 18), 18);
        chk("preempt prefix_done", count_done(1, 18), 0);
        analyze("preempt", 19, 120, 2, 12, 8, 4, 80);

        // Chime edge during an alarm is ignored.
        clear_log();
        bus.sound_model_57 = 1'b0;
        bus.sound_e_57     = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (s == 5) begin
                bus.sound_e_57     = 1'b0;
                bus.sound_model_57 = 1'b1;
            end
            if (s == 40) bus.sound_e_57 = 1'b1;
            if (s == 50) bus.sound_e_57 = 1'b0;
        end
        analyze("ignored", 1, 100, 2, 12, 8, 4, 80);

        // Asynchronous reset mid-sequence; no restart afterwards while the request stays low.
        clear_log();
        bus.sound_model_57 = 1'b0;
        bus.sound_e_57     = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("midreset pre_led", int'(led_log[10]), 1);
        bus.sound_e_57 = 1'b0;
        rst_n          = 1'b0;
        #2;
        chk("midreset outputs", int'({bus.buzzer_57, bus.led_57, bus.busy_57, bus.done_57}), 0);
        step();
        step();
        rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 10; i++) step();
        chk("midreset idle_after", count_busy(1, 10) + count_done(1, 10), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
